mlp_inference_core: RTL and testbench
=====================================

Name: mlp_inference_core

Overview:
- Two-layer fixed-point MLP datapath for 18x18 binary images: hidden = ReLU(W1·x), logits = W2·hidden.
- Combines the MM1 (binary-input dense layer), fullReLU and MM2 (dense layer) stages into one pipelined, clocked block.
- Sits between the image/weight loader and the argmax label stage, which consumes the logits.

Parameters:
- M1, 324, input pixels (binary vector length)
- N1, 10, hidden neurons
- N2, 10, output logits (M2 = N1 implicitly)
- WIDTH, 16, signed fixed-point word width
- FRAC, 14, fractional bits (Q2.14)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  image and weights valid this cycle
- image  in  M1  binary pixels; bit i = pixel i
- w1  in  M1*N1*WIDTH  layer-1 weights; element (j,i) at bits [(j*M1+i)*WIDTH +: WIDTH], j = hidden index
- w2  in  N2*N1*WIDTH  layer-2 weights; element (k,j) at bits [(k*N1+j)*WIDTH +: WIDTH], k = output index
- hidden  out  N1*WIDTH  registered post-ReLU hidden vector; element j at [j*WIDTH +: WIDTH]
- hidden_valid  out  1  hidden is valid
- logits  out  N2*WIDTH  registered output vector; element k at [k*WIDTH +: WIDTH]
- out_valid  out  1  logits are valid

Behaviour:
- Arithmetic: all words are signed two's complement Q2.14. Range is -2.0 (0x8000) to +1.99994 (0x7FFF).
- Stage 1 (layer 1 + ReLU), registered at edge 1:
  - acc1_j = sum over i of (image[i] ? w1(j,i) : 0).
  - acc1_j is at least 25 bits wide, so it never overflows.
  - Saturate acc1_j to 16 bits, then apply ReLU: negative becomes 0.
  - Result lands in hidden. hidden_valid <= in_valid.
- Stage 2 (layer 2), registered at edge 2:
  - acc2_k = sum over j of w2(k,j)*hidden_j.
  - Each product is full 32-bit; acc2_k is at least 36 bits.
  - Arithmetic shift right by FRAC (floor truncation, no rounding), then saturate to 16 bits into logits.
  - out_valid <= hidden_valid.
- Latency: 2 cycles from in_valid to out_valid. Throughput: 1 image per cycle. No backpressure.
- Stages are independent registers, so bubbles (in_valid = 0) propagate as valid = 0.
- Data registers update only when the corresponding valid is 1; otherwise they hold their value.
- w1 and w2 are sampled on the same edge as the stage that uses them. The loader keeps them stable while an image is in flight.
- Reset: on any edge with rst = 1:
  - hidden, logits, hidden_valid and out_valid all go to 0.
  - Reset mid-operation discards in-flight images.
  - in_valid on the reset edge is ignored.
  - The first valid output after reset deasserts arrives 2 cycles after the first accepted in_valid.
- Saturation boundaries: any value above 0x7FFF clamps to 0x7FFF. Any value below 0x8000 clamps to 0x8000; this can only occur in stage 2, since ReLU makes stage 1 non-negative.
- An all-zero image gives hidden = 0 and logits = 0.

Decomposition:
- Package mlp_pkg:
  - Constants M1, N1, N2, WIDTH, FRAC.
  - Typedef q_t (logic signed [WIDTH-1:0]).
  - Function sat_q (wide signed value -> q_t clamp).
- One sub-module, dense_relu_vec: an N-wide elementwise ReLU on a packed vector. It is reused for stage 1 and testable standalone.
- Both layer sums are generate/for loops inside mlp_inference_core.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 -> hidden = 0, logits = 0, hidden_valid = 0, out_valid = 0. After release, no out_valid until 2 cycles after the first accepted in_valid.
- Single pixel, identity W2: image = bit0 only, w1(j,0) = 0x1000 (0.25) for all j, others 0, w2 = diag 0x4000 -> hidden_j = 0x1000 at cycle 1, logits_k = 0x1000 at cycle 2.
- ReLU clamp: same as above with w1(j,0) = 0xF000 (-0.25) -> hidden = 0, logits = 0.
- Saturation: image all ones, w1 all 0x2000 (sum 162.0) -> hidden_j = 0x7FFF.
  - w2 all 0x4000 -> logits_k = 0x7FFF.
  - w2 all 0xC000 -> logits_k = 0x8000.
- Truncation: hidden_0 = 0x0001, w2(0,0) = 0x2000 (0.5), others 0 -> logits_0 = 0x0000 (floor). With w2(0,0) = 0xE000 (-0.5) -> logits_0 = 0xFFFF.
- Streaming: 4 distinct images on consecutive cycles, then a 1-cycle bubble, then rst asserted while 2 images are in flight -> first 4 results in order with latency 2, bubble gives out_valid = 0, in-flight results after reset never appear.

Source files
------------

// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mlp_pkg
// Purpose : Shared constants, the Q2.14 word type and the saturating clamp
//           used by the two-layer MLP inference datapath.
// Contents: M1/N1/N2/WIDTH/FRAC sizes, accumulator widths, q_t, sat_q().
// Revision: 1.0 - initial release
// ============================================================================
package mlp_pkg;

  localparam int M1    = 324;  // input pixels
  localparam int N1    = 10;   // hidden neurons
  localparam int N2    = 10;   // output logits
  localparam int WIDTH = 16;   // Q2.14 word
  localparam int FRAC  = 14;

  // Layer-1 sum: 324 * 2^15 < 2^24, so 25 signed bits cannot overflow.
  localparam int ACC1_W = 25;
  // Layer-2 sum: 10 full 32-bit products need 4 extra bits of growth.
  localparam int ACC2_W = 36;
  // Common width handed to the clamp so one function serves both stages.
  localparam int SAT_W  = 48;

  typedef logic signed [WIDTH-1:0] q_t;

  localparam logic signed [SAT_W-1:0] SAT_HI = 48'sd32767;
  localparam logic signed [SAT_W-1:0] SAT_LO = -48'sd32768;

  // Clamp a wide signed value into the Q2.14 range.
  function automatic q_t sat_q(input logic signed [SAT_W-1:0] v);
    q_t r;
    if (v > SAT_HI) begin
      r = 16'sh7FFF;
    end else if (v < SAT_LO) begin
      r = 16'sh8000;
    end else begin
      r = q_t'(v[WIDTH-1:0]);
    end
    return r;
  endfunction

endpackage : mlp_pkg
`default_nettype wire

// File: rtl/dense_relu_vec.sv
`default_nettype none
// ============================================================================
// Module  : dense_relu_vec
// Purpose : Elementwise ReLU over a packed vector of signed words.
//           Purely combinational; negative elements become zero.
// Ports   : din  [VEC_N*VEC_W-1:0]  packed signed input, element e at
//                                   [e*VEC_W +: VEC_W]
//           dout [VEC_N*VEC_W-1:0]  packed output, same layout
// Revision: 1.0 - initial release
// ============================================================================
module dense_relu_vec
  import mlp_pkg::*;
#(
  parameter int VEC_N = N1,
  parameter int VEC_W = WIDTH
) (
  input  logic [VEC_N*VEC_W-1:0] din,
  output logic [VEC_N*VEC_W-1:0] dout
);

  for (genvar e = 0; e < VEC_N; e++) begin : g_elem
    // The element's MSB is its sign bit.
    assign dout[e*VEC_W +: VEC_W] =
      din[e*VEC_W + VEC_W - 1] ? '0 : din[e*VEC_W +: VEC_W];
  end

endmodule : dense_relu_vec
`default_nettype wire

// File: rtl/mlp_inference_core.sv
`default_nettype none
// ============================================================================
// Module  : mlp_inference_core
// Purpose : Two-stage pipelined fixed-point MLP for 18x18 binary images.
//           Stage 1: hidden = ReLU(sat(W1 . image))      (registered, edge 1)
//           Stage 2: logits = sat((W2 . hidden) >>> FRAC) (registered, edge 2)
// Ports   : clk, rst        rising-edge clock, synchronous active-high reset
//           in_valid        image/w1 valid this cycle
//           image  [M1]     binary pixels, bit i = pixel i
//           w1     [M1*N1*WIDTH]  element (j,i) at [(j*M1+i)*WIDTH +: WIDTH]
//           w2     [N2*N1*WIDTH]  element (k,j) at [(k*N1+j)*WIDTH +: WIDTH]
//           hidden [N1*WIDTH], hidden_valid   stage-1 result
//           logits [N2*WIDTH], out_valid      stage-2 result
// Revision: 1.0 - initial release
// ============================================================================
module mlp_inference_core
  import mlp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [M1-1:0]            image,
  input  logic [M1*N1*WIDTH-1:0]   w1,
  input  logic [N2*N1*WIDTH-1:0]   w2,
  output logic [N1*WIDTH-1:0]      hidden,
  output logic                     hidden_valid,
  output logic [N2*WIDTH-1:0]      logits,
  output logic                     out_valid
);

  // --------------------------------------------------------------------------
  // Stage 1: masked sum of layer-1 weights, clamp, then ReLU
  // --------------------------------------------------------------------------
  logic [N1*WIDTH-1:0] sat1;
  logic [N1*WIDTH-1:0] relu1;

  for (genvar j = 0; j < N1; j++) begin : g_layer1
    logic signed [ACC1_W-1:0] acc;

    always_comb begin
      acc = '0;
      for (int i = 0; i < M1; i++) begin
        if (image[i]) begin
          acc = acc + ACC1_W'(signed'(w1[(j*M1+i)*WIDTH +: WIDTH]));
        end
      end
    end

    assign sat1[j*WIDTH +: WIDTH] =
      sat_q({{(SAT_W-ACC1_W){acc[ACC1_W-1]}}, acc});
  end

  dense_relu_vec #(
    .VEC_N (N1),
    .VEC_W (WIDTH)
  ) u_relu (
    .din  (sat1),
    .dout (relu1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hidden       <= '0;
      hidden_valid <= 1'b0;
    end else begin
      hidden_valid <= in_valid;
      if (in_valid) begin
        hidden <= relu1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: full-precision dot products, floor shift, clamp
  // --------------------------------------------------------------------------
  logic [N2*WIDTH-1:0] sat2;

  for (genvar k = 0; k < N2; k++) begin : g_layer2
    logic signed [ACC2_W-1:0]  acc;
    logic signed [ACC2_W-1:0]  shifted;
    q_t                        wk;
    q_t                        hj;
    logic signed [2*WIDTH-1:0] prod;

    always_comb begin
      acc  = '0;
      wk   = '0;
      hj   = '0;
      prod = '0;
      for (int j = 0; j < N1; j++) begin
        wk   = q_t'(w2[(k*N1+j)*WIDTH +: WIDTH]);
        hj   = q_t'(hidden[j*WIDTH +: WIDTH]);
        prod = wk * hj;
        acc  = acc + ACC2_W'(prod);
      end
    end

    // Arithmetic shift floors toward minus infinity; no rounding is applied.
    assign shifted = acc >>> FRAC;

    assign sat2[k*WIDTH +: WIDTH] =
      sat_q({{(SAT_W-ACC2_W){shifted[ACC2_W-1]}}, shifted});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      logits    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= hidden_valid;
      if (hidden_valid) begin
        logits <= sat2;
      end
    end
  end

endmodule : mlp_inference_core
`default_nettype wire

// File: tb/tb_mlp_inference_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_mlp_inference_core
// Purpose : Self-checking bench for mlp_inference_core. Expected hidden and
//           logits vectors are queued when an image is driven and popped by
//           a monitor when the matching valid strobe appears.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mlp_inference_core;
  import mlp_pkg::*;

  localparam int VW = N1 * WIDTH;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [M1-1:0]          image;
  logic [M1*N1*WIDTH-1:0] w1;
  logic [N2*N1*WIDTH-1:0] w2;
  logic [N1*WIDTH-1:0]    hidden;
  logic                   hidden_valid;
  logic [N2*WIDTH-1:0]    logits;
  logic                   out_valid;

  mlp_inference_core dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .image        (image),
    .w1           (w1),
    .w2           (w2),
    .hidden       (hidden),
    .hidden_valid (hidden_valid),
    .logits       (logits),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [VW-1:0] v;
    int            c;
  } exp_t;

  exp_t hq[$];
  exp_t lq[$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  function automatic void chk(string nm, logic [VW-1:0] act, logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic void chk_int(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hidden_valid !== 1'b0) begin
        if (hq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL hidden_unexpected actual=%b required=0", hidden_valid);
        end else begin
          exp_t e;
          e = hq.pop_front();
          chk("hidden_data", hidden, e.v);
          chk_int("hidden_latency", cyc - e.c, 1);
        end
      end
      if (out_valid !== 1'b0) begin
        if (lq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL logits_unexpected actual=%b required=0", out_valid);
        end else begin
          exp_t e;
          e = lq.pop_front();
          chk("logits_data", logits, e.v);
          chk_int("logits_latency", cyc - e.c, 2);
        end
      end
    end
  end

  // w1(j,0) = a for j==0, b for j>0; w1(j,i>0) = c.
  // w2(0,0) = d00; w2(k,k) = dg for k>0; off-diagonal = off.
  task automatic set_weights(input q_t a, input q_t b, input q_t c,
                             input q_t d00, input q_t dg, input q_t off);
    for (int j = 0; j < N1; j++) begin
      for (int i = 0; i < M1; i++) begin
        w1[(j*M1+i)*WIDTH +: WIDTH] = (i != 0) ? c : ((j == 0) ? a : b);
      end
    end
    for (int k = 0; k < N2; k++) begin
      for (int j = 0; j < N1; j++) begin
        w2[(k*N1+j)*WIDTH +: WIDTH] =
          (k != j) ? off : ((k == 0) ? d00 : dg);
      end
    end
  endtask

  function automatic logic [VW-1:0] vec2(q_t e0, q_t rest);
    logic [VW-1:0] v;
    for (int j = 0; j < N1; j++) v[j*WIDTH +: WIDTH] = (j == 0) ? e0 : rest;
    return v;
  endfunction

  // Entered just after a rising edge; presents one image for one cycle.
  task automatic send(input logic [VW-1:0] eh, input logic [VW-1:0] el,
                      input bit expect_l);
    exp_t e;
    in_valid = 1'b1;
    e.v = eh; e.c = cyc; hq.push_back(e);
    if (expect_l) begin
      e.v = el; lq.push_back(e);
    end
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk) #1;
  endtask

  typedef struct {
    string         name;
    logic [M1-1:0] img;
    q_t            a, b, c, d00, dg, off;
    q_t            h0, hr, l0, lr;
  } vec_t;

  vec_t vt[9];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M1-1:0] ones;
    logic [M1-1:0] im;
    ones = '1;

    vt[0] = '{"single_px",   324'h1, 16'h1000, 16'h1000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    vt[1] = '{"relu_clamp",  324'h1, 16'hF000, 16'hF000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[2] = '{"sat_pos",     ones,   16'h2000, 16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vt[3] = '{"sat_neg",     ones,   16'h2000, 16'h2000, 16'h2000, 16'hC000, 16'hC000, 16'hC000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    vt[4] = '{"trunc_pos",   324'h1, 16'h0001, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    vt[5] = '{"trunc_neg",   324'h1, 16'h0001, 16'h0000, 16'h0000, 16'hE000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
    vt[6] = '{"zero_img",    324'h0, 16'h2000, 16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[7] = '{"four_px",     324'hF, 16'h0800, 16'h0800, 16'h0800, 16'h4000, 16'h4000, 16'h0000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    vt[8] = '{"mixed_sign",  324'hF, 16'h7000, 16'h0800, 16'hF800, 16'h4000, 16'h4000, 16'h2000, 16'h5800, 16'h0000, 16'h5800, 16'h2C00};

    // ---------------- reset with in_valid held high ----------------
    rst      = 1'b1;
    in_valid = 1'b1;
    image    = ones;
    set_weights(16'h1000, 16'h1000, 16'h1000, 16'h4000, 16'h4000, 16'h4000);
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("reset_hidden", hidden, '0);
    chk("reset_logits", logits, '0);
    chk_int("reset_hidden_valid", int'(hidden_valid), 0);
    chk_int("reset_out_valid", int'(out_valid), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    idle(3);

    // ---------------- table-driven vectors ----------------
    for (int t = 0; t < 9; t++) begin
      image = vt[t].img;
      set_weights(vt[t].a, vt[t].b, vt[t].c, vt[t].d00, vt[t].dg, vt[t].off);
      send(vec2(vt[t].h0, vt[t].hr), vec2(vt[t].l0, vt[t].lr), 1'b1);
      idle(2);
    end

    // ---------------- streaming, bubble, reset in flight ----------------
    // w1 all 1/64, w2 diag 1.0 plus 1/16 off-diagonal: hidden = n*0x100,
    // logits = hidden*(1 + 9/16) = n*0x190 for an image with n pixels set.
    set_weights(16'h0100, 16'h0100, 16'h0100, 16'h4000, 16'h4000, 16'h0400);
    for (int n = 1; n <= 4; n++) begin
      im = '0;
      for (int p = 0; p < n; p++) im[n*20 + p] = 1'b1;
      image = im;
      send(vec2(q_t'(n*16'h0100), q_t'(n*16'h0100)),
           vec2(q_t'(n*16'h0190), q_t'(n*16'h0190)), 1'b1);
    end
    idle(1);  // bubble
    im = '0;
    for (int p = 0; p < 5; p++) im[200 + p] = 1'b1;
    image = im;
    send(vec2(16'h0500, 16'h0500), '0, 1'b0);  // killed before stage 2
    // Next image arrives together with reset and must be discarded.
    image    = ones;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("midrst_hidden", hidden, '0);
    chk("midrst_logits", logits, '0);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(4);

    // First accepted image after reset: latency checked by the monitor.
    im = '0;
    im[300] = 1'b1;
    im[301] = 1'b1;
    image = im;
    send(vec2(16'h0200, 16'h0200), vec2(16'h0320, 16'h0320), 1'b1);

    for (int i = 0; i < 10 && (hq.size() != 0 || lq.size() != 0); i++) begin
      @(posedge clk) #1;
    end
    idle(2);
    chk_int("drain_hidden_queue", hq.size(), 0);
    chk_int("drain_logits_queue", lq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mlp_inference_core
`default_nettype wire
